// File: rtl/elevator_call_panel.sv
// elevator_call_panel: button presses -> (from,to) requests via FIFO + valid/ready.
// Optional CALL_DEBOUNCE_EN: per-bit debounce filter ahead of edge detection.
module elevator_call_panel #(
  parameter int N_FLOORS   = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int DB_CYCLES  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_FLOORS-1:0]                hall_btn,
  input  logic [N_FLOORS-1:0]                car_btn,
  output logic                               req_valid,
  output logic [3:0]                         req_from,
  output logic [3:0]                         req_to,
  input  logic                               req_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               fifo_full,
  output logic                               busy,
  output logic                               drop_pulse
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [N_FLOORS-1:0] hall_lvl, car_lvl;
  logic [N_FLOORS-1:0] hall_q, car_q;

`ifdef CALL_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES+1);
  logic [DW-1:0] hall_cnt [N_FLOORS];
  logic [DW-1:0] car_cnt  [N_FLOORS];

  // Filtered level flips only after DB_CYCLES differing samples in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_lvl <= hall_btn;
      car_lvl  <= car_btn;
      for (int i = 0; i < N_FLOORS; i++) begin
        hall_cnt[i] <= '0;
        car_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_FLOORS; i++) begin
        if (hall_btn[i] == hall_lvl[i]) begin
          hall_cnt[i] <= '0;
        end else if (hall_cnt[i] == DW'(DB_CYCLES-1)) begin
          hall_lvl[i] <= hall_btn[i];
          hall_cnt[i] <= '0;
        end else begin
          hall_cnt[i] <= hall_cnt[i] + 1'b1;
        end
        if (car_btn[i] == car_lvl[i]) begin
          car_cnt[i] <= '0;
        end else if (car_cnt[i] == DW'(DB_CYCLES-1)) begin
          car_lvl[i] <= car_btn[i];
          car_cnt[i] <= '0;
        end else begin
          car_cnt[i] <= car_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign hall_lvl = hall_btn;
  assign car_lvl  = car_btn;
`endif

  // Edge history; loads raw levels in reset so held buttons never fire
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_q <= hall_btn;
      car_q  <= car_btn;
    end else begin
      hall_q <= hall_lvl;
      car_q  <= car_lvl;
    end
  end

  function automatic logic [3:0] first_code(input logic [N_FLOORS-1:0] e);
    logic [3:0] c;
    c = '0;
    for (int i = N_FLOORS-1; i >= 0; i--)
      if (e[i]) c = 4'(i+1);
    return c;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  state_t        state;
  logic [3:0]    from_r;
  logic [TW-1:0] timer;

  logic [3:0] mem_from [FIFO_DEPTH];
  logic [3:0] mem_to   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld;
  logic [PW-1:0] rd_ptr, wr_ptr, rd_n;
  logic [CW-1:0] count_n;
  logic [3:0]    head_from_n, head_to_n;

  logic [3:0] hall_code, car_code;
  logic in_wait, car_hit, pair_req, dup, pop, push, reject;

  assign hall_code = first_code(hall_lvl & ~hall_q);
  assign car_code  = first_code(car_lvl & ~car_q);
  assign in_wait   = (state == S_WAIT);
  assign busy      = in_wait;
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));

  // Accept/reject decision and next FIFO head
  always_comb begin
    pop      = req_valid & req_ready;
    car_hit  = in_wait && (car_code != 4'd0);
    pair_req = car_hit && (car_code != from_r);
    dup      = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (vld[i] && mem_from[i] == from_r && mem_to[i] == car_code)
        dup = 1'b1;
    push   = pair_req && !dup && (!fifo_full || pop);
    reject = (car_hit && car_code == from_r)
           || (pair_req && !dup && fifo_full && !pop)
           || (in_wait && car_code == 4'd0 && timer == '0);
    rd_n = pop ? ptr_inc(rd_ptr) : rd_ptr;
    unique case ({push, pop})
      2'b10:   count_n = fifo_count + 1'b1;
      2'b01:   count_n = fifo_count - 1'b1;
      default: count_n = fifo_count;
    endcase
    if (push && rd_n == wr_ptr) begin
      head_from_n = from_r;
      head_to_n   = car_code;
    end else begin
      head_from_n = mem_from[rd_n];
      head_to_n   = mem_to[rd_n];
    end
  end

  // Call FSM: latch origin, wait for destination, time out
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      from_r     <= '0;
      timer      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= reject;
      unique case (state)
        S_IDLE: begin
          if (hall_code != 4'd0) begin
            from_r <= hall_code;
            timer  <= TW'(TIMEOUT-1);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (car_code != 4'd0 || timer == '0)
            state <= S_IDLE;
          else
            timer <= timer - 1'b1;
        end
      endcase
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_from[wr_ptr] <= from_r;
      mem_to[wr_ptr]   <= car_code;
    end
  end

  // Queue control and registered request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      vld        <= '0;
      fifo_count <= '0;
      req_valid  <= 1'b0;
      req_from   <= 4'd0;
      req_to     <= 4'd0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_n;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      fifo_count <= count_n;
      req_valid  <= (count_n != '0);
      req_from   <= (count_n != '0) ? head_from_n : 4'd0;
      req_to     <= (count_n != '0) ? head_to_n : 4'd0;
    end
  end

endmodule

// File: tb/tb_elevator_call_panel.sv
// tb_elevator_call_panel: directed + random stimulus against a queue-based model.
// Outputs are compared every cycle at the falling edge.
module tb_elevator_call_panel;

  localparam int N   = 9;
  localparam int DEP = 4;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] hall_btn, car_btn;
  logic         req_valid, req_ready;
  logic [3:0]   req_from, req_to;
  logic [2:0]   fifo_count;
  logic         fifo_full, busy, drop_pulse;

  elevator_call_panel dut (
    .clk(clk), .rst(rst),
    .hall_btn(hall_btn), .car_btn(car_btn),
    .req_valid(req_valid), .req_from(req_from), .req_to(req_to),
    .req_ready(req_ready), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .busy(busy), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct { int f; int t; } pair_t;

  pair_t        q[$];
  bit           m_busy, m_drop;
  int           m_from, m_deadline, cnum;
  logic [N-1:0] m_ph, m_pc;
  int           checks = 0;
  int           failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] e);
    for (int i = 0; i < N; i++)
      if (e[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_step();
    int hc, cc;
    bit pop, push, d, dup;
    if (rst) begin
      q.delete();
      m_busy = 0;
      m_drop = 0;
      m_ph = hall_btn;
      m_pc = car_btn;
      cnum++;
      return;
    end
    hc = lowest(hall_btn & ~m_ph);
    cc = lowest(car_btn & ~m_pc);
    m_ph = hall_btn;
    m_pc = car_btn;
    pop  = (q.size() != 0) && req_ready;
    push = 0;
    d    = 0;
    if (!m_busy) begin
      if (hc != 0) begin
        m_busy = 1;
        m_from = hc;
        m_deadline = cnum + TMO;
      end
    end else if (cc != 0) begin
      m_busy = 0;
      if (cc == m_from) d = 1;
      else begin
        dup = 0;
        foreach (q[k]) if (q[k].f == m_from && q[k].t == cc) dup = 1;
        if (!dup) begin
          if (q.size() < DEP || pop) push = 1;
          else d = 1;
        end
      end
    end else if (cnum == m_deadline) begin
      m_busy = 0;
      d = 1;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{m_from, cc});
    m_drop = d;
    cnum++;
  endtask

  task automatic check_model();
    bit ne;
    ne = (q.size() != 0);
    chk("req_valid", req_valid, ne);
    chk("req_from", req_from, ne ? q[0].f : 0);
    chk("req_to", req_to, ne ? q[0].t : 0);
    chk("fifo_count", fifo_count, q.size());
    chk("fifo_full", fifo_full, q.size() == DEP);
    chk("busy", busy, m_busy);
    chk("drop_pulse", drop_pulse, m_drop);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_pair(input int f, input int t);
    hall_btn = '0;
    hall_btn[f-1] = 1'b1;
    cyc();
    hall_btn = '0;
    cyc();
    car_btn = '0;
    car_btn[t-1] = 1'b1;
    cyc();
    car_btn = '0;
  endtask

  initial begin
    int mode;
    int exf[4];
    int ext[4];
    exf = '{2, 3, 7, 9};
    ext = '{5, 1, 4, 6};
    cnum = 0;
    rst = 1'b1;
    hall_btn = '0;
    car_btn = '0;
    req_ready = 1'b0;
    @(posedge clk);
    #1;
    model_step();
    chk("rst_valid", req_valid, 0);
    chk("rst_from", req_from, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_pulse, 0);
    cyc();
    rst = 1'b0;

    req_ready = 1'b1;
    cyc();
    hall_btn[4] = 1'b1;
    cyc();
    chk("s1_busy", busy, 1);
    hall_btn = '0;
    cyc();
    cyc();
    car_btn[0] = 1'b1;
    cyc();
    chk("s1_valid", req_valid, 1);
    chk("s1_from", req_from, 5);
    chk("s1_to", req_to, 1);
    car_btn = '0;
    cyc();
    chk("s1_empty", req_valid, 0);

    hall_btn[2] = 1'b1;
    cyc();
    hall_btn = '0;
    repeat (15) cyc();
    chk("s2_busy_last", busy, 1);
    cyc();
    chk("s2_timeout_drop", drop_pulse, 1);
    chk("s2_idle", busy, 0);
    cyc();
    chk("s2_drop_once", drop_pulse, 0);

    req_ready = 1'b0;
    hall_btn[2] = 1'b1;
    cyc();
    hall_btn = '0;
    repeat (15) cyc();
    car_btn[7] = 1'b1;
    cyc();
    car_btn = '0;
    chk("s2_late_count", fifo_count, 1);
    chk("s2_late_from", req_from, 3);
    chk("s2_late_to", req_to, 8);
    chk("s2_late_nodrop", drop_pulse, 0);
    req_ready = 1'b1;
    cyc();
    chk("s2_drained", fifo_count, 0);

    press_pair(2, 2);
    chk("s3_drop", drop_pulse, 1);
    chk("s3_count", fifo_count, 0);
    cyc();

    req_ready = 1'b0;
    press_pair(2, 5);
    press_pair(3, 1);
    press_pair(7, 4);
    press_pair(9, 6);
    chk("s4_count4", fifo_count, 4);
    press_pair(1, 8);
    chk("s4_full_drop", drop_pulse, 1);
    chk("s4_full", fifo_full, 1);
    chk("s4_count", fifo_count, 4);
    req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s4_head_from", req_from, exf[k]);
      chk("s4_head_to", req_to, ext[k]);
      cyc();
    end
    chk("s4_empty", req_valid, 0);

    req_ready = 1'b0;
    press_pair(6, 4);
    press_pair(6, 4);
    chk("s5_dup_count", fifo_count, 1);
    chk("s5_dup_nodrop", drop_pulse, 0);
    hall_btn = 9'b001000010;
    cyc();
    hall_btn = '0;
    cyc();
    car_btn[8] = 1'b1;
    cyc();
    car_btn = '0;
    chk("s5_count2", fifo_count, 2);
    req_ready = 1'b1;
    cyc();
    chk("s5_lowest_from", req_from, 2);
    chk("s5_lowest_to", req_to, 9);
    cyc();

    req_ready = 1'b0;
    press_pair(4, 7);
    press_pair(5, 8);
    hall_btn[0] = 1'b1;
    cyc();
    chk("s6_busy", busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("s6_count", fifo_count, 0);
    chk("s6_valid", req_valid, 0);
    chk("s6_busy0", busy, 0);
    cyc();
    hall_btn = '0;
    cyc();
    car_btn[2] = 1'b1;
    cyc();
    car_btn = '0;
    cyc();
    chk("s6_no_req", fifo_count, 0);
    chk("s6_not_busy", busy, 0);

    mode = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 64 == 0) mode = int'($urandom_range(0, 2));
      req_ready = (mode == 2) ? 1'b1 :
                  (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($urandom_range(0, 3) == 0)
        hall_btn[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0)
        car_btn[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) hall_btn = N'($urandom);
      if ($urandom_range(0, 49) == 0) car_btn = N'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
